// File: rtl/packet_check_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | packet_check_if : word-aligned transceiver receive bus (data + K flags)    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface packet_check_if;
  logic [31:0] gt_rx_data;
  logic [3:0]  gt_rx_ctrl;

  modport master (output gt_rx_data, output gt_rx_ctrl);
  modport slave  (input  gt_rx_data, input  gt_rx_ctrl);
endinterface
`default_nettype wire

// File: rtl/packet_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | packet_check : receive-side frame checker with good/bad packet counters    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module packet_check #(
  parameter int unsigned MAX_LEN  = 1024,
  parameter logic [7:0]  EXP_TYPE = 8'd8
) (
  input  wire logic         rx_clk,
  input  wire logic         rst_n,
  packet_check_if.slave     gt_rx_i,
  output logic [31:0]       packet_cnt_o,
  output logic [31:0]       error_packet_cnt_o,
  output logic [15:0]       last_len_o,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic              in_packet
);

  localparam logic [7:0]  c_K_SOP   = 8'hFB;
  localparam logic [7:0]  c_K_EOP   = 8'hFD;
  localparam logic [3:0]  c_CTRL_K0 = 4'b0001;
  localparam logic [16:0] c_MAX_LEN = 17'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_EOP     = 2'd2
  } state_t;

  // Reset asserts asynchronously, releases two clocks later
  logic [1:0] rst_sync_q;
  logic       w_rst_core_n;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign w_rst_core_n = rst_sync_q[1];

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic        err_q, err_d;
  logic [15:0] last_len_q, last_len_d;
  logic        done_q, done_d;
  logic        perr_q, perr_d;
  logic [31:0] pkt_cnt_q, err_cnt_q;

  logic [31:0] w_data;
  logic [3:0]  w_ctrl;
  logic        w_is_sop;
  logic        w_is_eop;
  logic [15:0] w_sop_len;
  logic [7:0]  w_sop_type;
  logic        w_len_ok;
  logic [31:0] w_exp_word;
  logic        w_take_sop;

  assign w_data     = gt_rx_i.gt_rx_data;
  assign w_ctrl     = gt_rx_i.gt_rx_ctrl;
  assign w_is_sop   = (w_ctrl == c_CTRL_K0) && (w_data[7:0] == c_K_SOP);
  assign w_is_eop   = (w_ctrl == c_CTRL_K0) && (w_data[7:0] == c_K_EOP);
  assign w_sop_len  = w_data[31:16];
  assign w_sop_type = w_data[15:8];
  assign w_len_ok   = (w_sop_len != 16'd0) && ({1'b0, w_sop_len} <= c_MAX_LEN);
  assign w_exp_word = {4{cnt_q[7:0]}};

  always_ff @(posedge rx_clk or negedge w_rst_core_n) begin
    if (!w_rst_core_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      last_len_q <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      last_len_q <= last_len_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      // Counters move on the same edge that raises pkt_done
      if (done_d) begin
        if (perr_d) begin
          if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
        end else begin
          if (pkt_cnt_q != 32'hFFFF_FFFF) pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    last_len_d = last_len_q;
    done_d     = 1'b0;
    perr_d     = 1'b0;
    w_take_sop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_is_sop) w_take_sop = 1'b1;
      end

      ST_PAYLOAD: begin
        if (w_ctrl == 4'b0000) begin
          if (w_data != w_exp_word) err_d = 1'b1;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == (len_q - 16'd1)) state_d = ST_EOP;
        end else begin
          // Short packet: close it out, a SOP here starts the next one
          done_d  = 1'b1;
          perr_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
          if (w_is_sop) w_take_sop = 1'b1;
        end
      end

      ST_EOP: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (w_is_eop) begin
          perr_d = err_q;
        end else begin
          perr_d = 1'b1;
          if (w_is_sop) w_take_sop = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_take_sop) begin
      last_len_d = w_sop_len;
      if (w_len_ok) begin
        state_d = ST_PAYLOAD;
        cnt_d   = '0;
        len_d   = w_sop_len;
        err_d   = (w_sop_type != EXP_TYPE);
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        perr_d  = 1'b1;
      end
    end
  end

  assign packet_cnt_o       = pkt_cnt_q;
  assign error_packet_cnt_o = err_cnt_q;
  assign last_len_o         = last_len_q;
  assign pkt_done           = done_q;
  assign pkt_err            = perr_q;
  assign in_packet          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_packet_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_packet_check : directed self-checking bench for packet_check            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_packet_check;

  logic        rx_clk;
  logic        rst_n;
  logic [31:0] packet_cnt_o;
  logic [31:0] error_packet_cnt_o;
  logic [15:0] last_len_o;
  logic        pkt_done;
  logic        pkt_err;
  logic        in_packet;

  int errors;
  int checks;

  packet_check_if rx_if ();

  packet_check #(
    .MAX_LEN  (1024),
    .EXP_TYPE (8'd8)
  ) dut (
    .rx_clk             (rx_clk),
    .rst_n              (rst_n),
    .gt_rx_i            (rx_if.slave),
    .packet_cnt_o       (packet_cnt_o),
    .error_packet_cnt_o (error_packet_cnt_o),
    .last_len_o         (last_len_o),
    .pkt_done           (pkt_done),
    .pkt_err            (pkt_err),
    .in_packet          (in_packet)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic step(input logic [3:0] c, input logic [31:0] d);
    @(negedge rx_clk);
    rx_if.gt_rx_ctrl = c;
    rx_if.gt_rx_data = d;
  endtask

  task automatic idle_word();
    step(4'b0001, 32'h0000_00BC);
  endtask

  task automatic sop(input logic [7:0] t, input logic [15:0] l);
    step(4'b0001, {l, t, 8'hFB});
  endtask

  task automatic eop();
    step(4'b0001, 32'h0000_00FD);
  endtask

  function automatic logic [31:0] pw(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {b, b, b, b};
  endfunction

  task automatic send_payload(input int first, input int count, input int bad_idx,
                              input logic [31:0] bad_val);
    logic [31:0] w;
    for (int i = first; i < first + count; i++) begin
      w = (i == bad_idx) ? bad_val : pw(i);
      step(4'b0000, w);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_word();
    idle_word();
    checks++;
    if ({packet_cnt_o, error_packet_cnt_o, last_len_o} !== 80'd0) begin
      errors++;
      $display("FAIL reset_counts: got pkt=%h err=%h len=%h, want all 0",
               packet_cnt_o, error_packet_cnt_o, last_len_o);
    end
    checks++;
    if ({pkt_done, pkt_err, in_packet} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got done/err/inpkt=%b, want 000", {pkt_done, pkt_err, in_packet});
    end
    rst_n = 1'b1;
    repeat (4) idle_word();
  endtask

  task automatic test_good();
    sop(8'd8, 16'd256);
    step(4'b0000, pw(0));
    checks++;
    if (in_packet !== 1'b1) begin
      errors++;
      $display("FAIL good_in_packet: got %b, want 1", in_packet);
    end
    send_payload(1, 255, -1, 32'h0);
    eop();
    checks++;
    if (pkt_done !== 1'b0) begin
      errors++;
      $display("FAIL good_done_early: got %b, want 0", pkt_done);
    end
    idle_word();
    checks++;
    if ({pkt_done, pkt_err, in_packet} !== 3'b100) begin
      errors++;
      $display("FAIL good_pulse: got done/err/inpkt=%b, want 100", {pkt_done, pkt_err, in_packet});
    end
    checks++;
    if (packet_cnt_o !== 32'd1 || error_packet_cnt_o !== 32'd0 || last_len_o !== 16'd256) begin
      errors++;
      $display("FAIL good_counts: got pkt=%0d err=%0d len=%0d, want 1 0 256",
               packet_cnt_o, error_packet_cnt_o, last_len_o);
    end
    idle_word();
    checks++;
    if (pkt_done !== 1'b0) begin
      errors++;
      $display("FAIL good_pulse_width: got %b, want 0", pkt_done);
    end
  endtask

  task automatic test_bad_payload();
    sop(8'd8, 16'd256);
    send_payload(0, 256, 17, 32'h1111_0011);
    eop();
    idle_word();
    checks++;
    if ({pkt_done, pkt_err} !== 2'b11) begin
      errors++;
      $display("FAIL badpay_pulse: got done/err=%b, want 11", {pkt_done, pkt_err});
    end
    checks++;
    if (packet_cnt_o !== 32'd1 || error_packet_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL badpay_counts: got pkt=%0d err=%0d, want 1 1", packet_cnt_o, error_packet_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    sop(8'd8, 16'd256);
    send_payload(0, 100, -1, 32'h0);
    sop(8'd8, 16'd4);
    step(4'b0000, pw(0));
    checks++;
    if ({pkt_done, pkt_err, in_packet} !== 3'b111) begin
      errors++;
      $display("FAIL short_pulse: got done/err/inpkt=%b, want 111", {pkt_done, pkt_err, in_packet});
    end
    checks++;
    if (error_packet_cnt_o !== 32'd2 || packet_cnt_o !== 32'd1 || last_len_o !== 16'd4) begin
      errors++;
      $display("FAIL short_counts: got pkt=%0d err=%0d len=%0d, want 1 2 4",
               packet_cnt_o, error_packet_cnt_o, last_len_o);
    end
    send_payload(1, 3, -1, 32'h0);
    eop();
    idle_word();
    checks++;
    if ({pkt_done, pkt_err} !== 2'b10 || packet_cnt_o !== 32'd2 || error_packet_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL b2b_good: got done/err=%b pkt=%0d err=%0d, want 10 2 2",
               {pkt_done, pkt_err}, packet_cnt_o, error_packet_cnt_o);
    end
  endtask

  task automatic test_len_bounds();
    sop(8'd8, 16'd0);
    sop(8'd8, 16'd1025);
    checks++;
    if ({pkt_done, pkt_err, in_packet} !== 3'b110 || last_len_o !== 16'd0 || error_packet_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL len_zero: got done/err/inpkt=%b len=%0d err=%0d, want 110 0 3",
               {pkt_done, pkt_err, in_packet}, last_len_o, error_packet_cnt_o);
    end
    idle_word();
    checks++;
    if ({pkt_done, pkt_err, in_packet} !== 3'b110 || last_len_o !== 16'd1025 || error_packet_cnt_o !== 32'd4) begin
      errors++;
      $display("FAIL len_over: got done/err/inpkt=%b len=%0d err=%0d, want 110 1025 4",
               {pkt_done, pkt_err, in_packet}, last_len_o, error_packet_cnt_o);
    end
    idle_word();
    sop(8'd8, 16'd1024);
    send_payload(0, 1024, -1, 32'h0);
    eop();
    idle_word();
    checks++;
    if ({pkt_done, pkt_err} !== 2'b10 || packet_cnt_o !== 32'd3 || last_len_o !== 16'd1024) begin
      errors++;
      $display("FAIL len_max: got done/err=%b pkt=%0d len=%0d, want 10 3 1024",
               {pkt_done, pkt_err}, packet_cnt_o, last_len_o);
    end
  endtask

  task automatic test_bad_type();
    sop(8'd9, 16'd2);
    send_payload(0, 2, -1, 32'h0);
    eop();
    idle_word();
    checks++;
    if ({pkt_done, pkt_err} !== 2'b11 || error_packet_cnt_o !== 32'd5 || packet_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL bad_type: got done/err=%b pkt=%0d err=%0d, want 11 3 5",
               {pkt_done, pkt_err}, packet_cnt_o, error_packet_cnt_o);
    end
  endtask

  task automatic test_saturation();
    idle_word();
    force dut.pkt_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.pkt_cnt_q;
    for (int k = 0; k < 3; k++) begin
      sop(8'd8, 16'd2);
      send_payload(0, 2, -1, 32'h0);
      eop();
      idle_word();
      checks++;
      if (packet_cnt_o !== 32'hFFFF_FFFF || error_packet_cnt_o !== 32'd5) begin
        errors++;
        $display("FAIL saturate_%0d: got pkt=%h err=%0d, want ffffffff 5",
                 k, packet_cnt_o, error_packet_cnt_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    sop(8'd8, 16'd8);
    send_payload(0, 3, -1, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({packet_cnt_o, error_packet_cnt_o, last_len_o} !== 80'd0 ||
        {pkt_done, pkt_err, in_packet} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_async: got pkt=%h err=%h len=%h flags=%b, want all 0",
               packet_cnt_o, error_packet_cnt_o, last_len_o, {pkt_done, pkt_err, in_packet});
    end
    send_payload(3, 2, -1, 32'h0);
    rst_n = 1'b1;
    repeat (4) idle_word();
    checks++;
    if ({pkt_done, in_packet} !== 2'b00 || packet_cnt_o !== 32'd0 || error_packet_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL midreset_discard: got done/inpkt=%b pkt=%0d err=%0d, want 00 0 0",
               {pkt_done, in_packet}, packet_cnt_o, error_packet_cnt_o);
    end
    sop(8'd8, 16'd3);
    send_payload(0, 3, -1, 32'h0);
    eop();
    idle_word();
    checks++;
    if ({pkt_done, pkt_err} !== 2'b10 || packet_cnt_o !== 32'd1 || error_packet_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL midreset_recover: got done/err=%b pkt=%0d err=%0d, want 10 1 0",
               {pkt_done, pkt_err}, packet_cnt_o, error_packet_cnt_o);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    rx_if.gt_rx_ctrl = 4'b0001;
    rx_if.gt_rx_data = 32'h0000_00BC;
    test_reset();
    test_good();
    test_bad_payload();
    test_back_to_back();
    test_len_bounds();
    test_bad_type();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
